sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO, the next-generation buffer for the same-clock paths of the design. It generalises the dual-clock FIFO with:
- arbitrary (non-power-of-two) depth
- programmable almost-full and almost-empty thresholds
- an occupancy count
- sticky overflow and underflow error flags
- a selectable first-word-fall-through (FWFT) read mode

It sits between same-clock producer/consumer pairs, such as the capture and packetiser paths, where no clock crossing is needed.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDRESS_WIDTH, 4, pointer width; 2^ADDRESS_WIDTH must be ≥ FIFO_DEPTH.
- FIFO_DEPTH, 1<<ADDRESS_WIDTH, number of entries; legal range 2..2^ADDRESS_WIDTH.
- ALMOST_FULL_THRESH, FIFO_DEPTH-2, AlmostFull_out asserts when count ≥ this value.
- ALMOST_EMPTY_THRESH, 2, AlmostEmpty_out asserts when count ≤ this value.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- Clk  in  1  single clock; all logic samples on the rising edge.
- Reset_in  in  1  synchronous, active-high reset.
- Clear_in  in  1  synchronous flush; empties the FIFO and keeps the error flags.
- Data_in  in  DATA_WIDTH  write data.
- WriteEn_in  in  1  write request.
- Full_out  out  1  registered; FIFO holds FIFO_DEPTH words.
- AlmostFull_out  out  1  registered threshold flag.
- Data_out  out  DATA_WIDTH  read data.
- ReadEn_in  in  1  read request; in FWFT mode it pops the head word.
- Empty_out  out  1  registered; no readable word.
- AlmostEmpty_out  out  1  registered threshold flag.
- Count_out  out  ADDRESS_WIDTH+1  occupancy, 0..FIFO_DEPTH.
- Overflow_out  out  1  sticky; a write was attempted while Full_out=1.
- Underflow_out  out  1  sticky; a read was attempted while Empty_out=1.

## Operation
- Write acceptance: a write is accepted when WriteEn_in & !Full_out. Data is stored at the write pointer, and the write pointer increments.
- Read acceptance: a read is accepted when ReadEn_in & !Empty_out. The read pointer increments.
- Pointers are binary and wrap from FIFO_DEPTH-1 to 0. There is no power-of-two assumption.
- Count update: next count = count + accepted write − accepted read.
  - All flags are registered and computed from next count.
  - Full_out = (count == FIFO_DEPTH); Empty_out = (count == 0).
- Simultaneous read and write:
  - Both are accepted when neither is blocked; count is unchanged.
  - When full, the write is rejected even if a read is accepted in the same cycle.
  - When empty, the read is rejected even if a write is accepted in the same cycle.
- Error flags: Overflow_out is set on WriteEn_in & Full_out. Underflow_out is set on ReadEn_in & Empty_out. Both stay set until Reset_in.
- Read modes:
  - FWFT=0: Data_out loads the head word on the edge after an accepted read, and holds its value otherwise. A rejected read leaves Data_out unchanged.
  - FWFT=1: Data_out always presents the head word while Empty_out=0. An accepted read advances Data_out to the next word, or leaves it stale when the FIFO becomes empty.
    - A write into an empty FIFO is bypassed to Data_out.
    - Count_out includes the word on Data_out.
- Priority: Reset_in > Clear_in > read/write.
  - Clear_in zeroes the pointers and count, and sets flags to their reset values except the error flags.
  - Read and write requests in the Clear_in cycle are ignored.

## Timing
- Reset values: Empty_out=1, AlmostEmpty_out=1, Full_out=0, AlmostFull_out=(ALMOST_FULL_THRESH==0), Count_out=0, Data_out=0, Overflow_out=0, Underflow_out=0.
- Write at edge n:
  - Count_out, Empty_out and the almost flags update after edge n.
  - The word is readable from cycle n+1.
  - FWFT=1: Data_out is valid after edge n.
- Read at edge n, FWFT=0: Data_out is valid after edge n (one-cycle read latency).
- Full_out asserts after the edge that accepts the FIFO_DEPTH-th word, and deasserts after the edge that accepts a read.
- Throughput: one write and one read per cycle, sustained, including across pointer wrap.

## Structure
- Shared header fifo_defs.vh (included like the existing FIFO includes): mode constants FWFT_OFF/FWFT_ON, and a clog2 helper function for parameter checks.
- One sub-module, fifo_ptr_counter: a wrapping binary counter parametrised by width and modulus, with enable and synchronous clear. It is instantiated twice, for the write and read pointers.
- Storage is an inferred single-clock RAM, Mem[FIFO_DEPTH-1:0].

## Test plan
- Depth 5 (ADDRESS_WIDTH=3), FWFT=0: write 0x11..0x15, then one more write with 0x99 → Full_out=1 after the 5th write; the 0x99 write is dropped and Overflow_out=1. Five reads return 0x11..0x15 each one cycle later; Empty_out=1 after the last read.
- Depth 16: continuous simultaneous read/write for 40 cycles from count 3 → Count_out stays 3; data order is preserved across two pointer wraps.
- FWFT=1: a single write of 0xA5 into an empty FIFO → Data_out=0xA5 and Empty_out=0 after that edge. ReadEn_in for one cycle → Empty_out=1 and Count_out=0.
- Thresholds AF=14 and AE=2, depth 16: fill one word per cycle → AlmostEmpty_out drops at count 3 and AlmostFull_out rises at count 14. Draining reverses both at the same counts.
- Read while empty → Underflow_out=1 and Data_out unchanged. Then Clear_in at count 7 → count 0 and Empty_out=1, while Underflow_out stays 1. Then Reset_in → Underflow_out=0.
- Reset_in asserted mid-burst together with WriteEn_in and ReadEn_in → all outputs at reset values on the next cycle; the concurrent write is not stored.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO: read-mode constants and a
// ceiling-log2 helper used for elaboration-time parameter checks.
package sync_fifo_pkg;

    // Read-mode selector values for the FWFT parameter.
    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    // Number of address bits needed to index 'value' distinct locations.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ptr_counter.sv
// Wrapping binary counter: counts 0..MODULUS-1 and wraps to 0. MODULUS
// need not be a power of two. Synchronous clear has priority over enable.
module fifo_ptr_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] value_o
);

    localparam logic [WIDTH-1:0] LAST_VALUE = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next value: clear to zero, otherwise advance with wrap when enabled.
    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (en_i) begin
            value_d = (value_q == LAST_VALUE) ? '0 : value_q + WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        value_q <= value_d;
    end

    assign value_o = value_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, registered status flags computed
// from the next occupancy, sticky overflow/underflow flags and a selectable
// standard (registered) or first-word-fall-through read mode.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH          = 8,
    parameter int ADDRESS_WIDTH       = 4,
    parameter int FIFO_DEPTH          = 1 << ADDRESS_WIDTH,
    parameter int ALMOST_FULL_THRESH  = FIFO_DEPTH - 2,
    parameter int ALMOST_EMPTY_THRESH = 2,
    parameter int FWFT                = FWFT_OFF
) (
    input  logic                     Clk,
    input  logic                     Reset_in,
    input  logic                     Clear_in,
    input  logic [DATA_WIDTH-1:0]    Data_in,
    input  logic                     WriteEn_in,
    output logic                     Full_out,
    output logic                     AlmostFull_out,
    output logic [DATA_WIDTH-1:0]    Data_out,
    input  logic                     ReadEn_in,
    output logic                     Empty_out,
    output logic                     AlmostEmpty_out,
    output logic [ADDRESS_WIDTH:0]   Count_out,
    output logic                     Overflow_out,
    output logic                     Underflow_out
);

    localparam int CW = ADDRESS_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_THRESH);

    // Reject depths the pointer width cannot address.
    if (FIFO_DEPTH < 2 || clog2(FIFO_DEPTH) > ADDRESS_WIDTH) begin : g_bad_depth
        $error("sync_fifo: FIFO_DEPTH must be in 2..2**ADDRESS_WIDTH");
    end

    // Storage: single-clock RAM, one write port and one registered read port.
    logic [DATA_WIDTH-1:0] mem_q [0:FIFO_DEPTH-1];

    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  full_q;
    logic                  empty_q;
    logic                  afull_q;
    logic                  aempty_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ptr_clr;
    logic [1:0]            ptr_en;
    logic [1:0][ADDRESS_WIDTH-1:0] ptr_val;
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_ptr;

    // Requests are ignored during reset and flush; full blocks writes and
    // empty blocks reads even when the opposite side is accepted.
    assign wr_acc  = WriteEn_in & ~full_q  & ~Clear_in & ~Reset_in;
    assign rd_acc  = ReadEn_in  & ~empty_q & ~Clear_in & ~Reset_in;
    assign ptr_clr = Reset_in | Clear_in;

    // Index 0 is the write pointer, index 1 the read pointer.
    assign ptr_en = {rd_acc, wr_acc};

    for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
        fifo_ptr_counter #(
            .WIDTH   (ADDRESS_WIDTH),
            .MODULUS (FIFO_DEPTH)
        ) u_ptr (
            .clk_i   (Clk),
            .clr_i   (ptr_clr),
            .en_i    (ptr_en[gi]),
            .value_o (ptr_val[gi])
        );
    end

    assign wr_ptr = ptr_val[0];
    assign rd_ptr = ptr_val[1];

    // Next occupancy: flush/reset empties, otherwise +write -read.
    always_comb begin
        count_d = count_q;
        if (Reset_in || Clear_in) begin
            count_d = '0;
        end else if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    // Occupancy and status flags, all registered from the next count;
    // error flags survive a flush and only clear on reset.
    always_ff @(posedge Clk) begin
        if (Reset_in) begin
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= (ALMOST_FULL_THRESH == 0);
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            full_q   <= (count_d == DEPTH_C);
            empty_q  <= (count_d == '0);
            afull_q  <= (count_d >= AF_C);
            aempty_q <= (count_d <= AE_C);
            if (!Clear_in) begin
                if (WriteEn_in && full_q) begin
                    overflow_q <= 1'b1;
                end
                if (ReadEn_in && empty_q) begin
                    underflow_q <= 1'b1;
                end
            end
        end
    end

    // RAM write port.
    always_ff @(posedge Clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr] <= Data_in;
        end
    end

    if (FWFT == FWFT_ON) begin : g_fwft
        // In FWFT mode the read pointer addresses the word already on
        // Data_out, so a pop fetches the entry after it.
        localparam logic [ADDRESS_WIDTH-1:0] LAST_PTR = ADDRESS_WIDTH'(FIFO_DEPTH - 1);
        logic [ADDRESS_WIDTH-1:0] rd_nxt;

        assign rd_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + ADDRESS_WIDTH'(1);

        // Head register: bypass a write that becomes the new head, fetch the
        // following entry on a pop, hold (stale) when the pop empties it.
        always_ff @(posedge Clk) begin
            if (Reset_in) begin
                data_q <= '0;
            end else if (wr_acc && (empty_q || (rd_acc && count_q == CW'(1)))) begin
                data_q <= Data_in;
            end else if (rd_acc && count_q > CW'(1)) begin
                data_q <= mem_q[rd_nxt];
            end
        end
    end else begin : g_std
        // Standard mode: registered read of the head on an accepted read.
        always_ff @(posedge Clk) begin
            if (Reset_in) begin
                data_q <= '0;
            end else if (rd_acc) begin
                data_q <= mem_q[rd_ptr];
            end
        end
    end

    assign Full_out        = full_q;
    assign AlmostFull_out  = afull_q;
    assign Empty_out       = empty_q;
    assign AlmostEmpty_out = aempty_q;
    assign Count_out       = count_q;
    assign Overflow_out    = overflow_q;
    assign Underflow_out   = underflow_q;
    assign Data_out        = data_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: three instances (depth 5 standard, depth 16 standard
// with AF=14/AE=2, depth 16 FWFT) driven by directed and random steps and
// compared every cycle against a list-based reference model.
module tb_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [3];
    logic       clr [3];
    logic       we  [3];
    logic       re  [3];
    logic [7:0] din [3];

    logic [7:0] dout   [3];
    logic [4:0] cnt    [3];
    logic       full   [3];
    logic       afull  [3];
    logic       empty  [3];
    logic       aempty [3];
    logic       ovf    [3];
    logic       unf    [3];
    logic [3:0] cnt_a;

    assign cnt[0] = {1'b0, cnt_a};

    localparam int DEPTH_M [3] = '{5, 16, 16};
    localparam int AF_M    [3] = '{3, 14, 14};
    localparam int AE_M    [3] = '{2, 2, 2};
    localparam int FWFT_M  [3] = '{0, 0, 1};

    sync_fifo #(
        .DATA_WIDTH(8), .ADDRESS_WIDTH(3), .FIFO_DEPTH(5),
        .ALMOST_FULL_THRESH(3), .ALMOST_EMPTY_THRESH(2), .FWFT(0)
    ) dut_a (
        .Clk(clk), .Reset_in(rst[0]), .Clear_in(clr[0]), .Data_in(din[0]),
        .WriteEn_in(we[0]), .Full_out(full[0]), .AlmostFull_out(afull[0]),
        .Data_out(dout[0]), .ReadEn_in(re[0]), .Empty_out(empty[0]),
        .AlmostEmpty_out(aempty[0]), .Count_out(cnt_a),
        .Overflow_out(ovf[0]), .Underflow_out(unf[0])
    );

    sync_fifo #(
        .DATA_WIDTH(8), .ADDRESS_WIDTH(4), .FIFO_DEPTH(16),
        .ALMOST_FULL_THRESH(14), .ALMOST_EMPTY_THRESH(2), .FWFT(0)
    ) dut_b (
        .Clk(clk), .Reset_in(rst[1]), .Clear_in(clr[1]), .Data_in(din[1]),
        .WriteEn_in(we[1]), .Full_out(full[1]), .AlmostFull_out(afull[1]),
        .Data_out(dout[1]), .ReadEn_in(re[1]), .Empty_out(empty[1]),
        .AlmostEmpty_out(aempty[1]), .Count_out(cnt[1]),
        .Overflow_out(ovf[1]), .Underflow_out(unf[1])
    );

    sync_fifo #(
        .DATA_WIDTH(8), .ADDRESS_WIDTH(4), .FIFO_DEPTH(16),
        .ALMOST_FULL_THRESH(14), .ALMOST_EMPTY_THRESH(2), .FWFT(1)
    ) dut_c (
        .Clk(clk), .Reset_in(rst[2]), .Clear_in(clr[2]), .Data_in(din[2]),
        .WriteEn_in(we[2]), .Full_out(full[2]), .AlmostFull_out(afull[2]),
        .Data_out(dout[2]), .ReadEn_in(re[2]), .Empty_out(empty[2]),
        .AlmostEmpty_out(aempty[2]), .Count_out(cnt[2]),
        .Overflow_out(ovf[2]), .Underflow_out(unf[2])
    );

    // Reference model: ordered list of stored words per instance.
    logic [7:0] mdata [3][16];
    int         msize [3];
    logic       movf  [3];
    logic       munf  [3];
    logic [7:0] mdout [3];

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else begin
            checks_failed++;
            $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, i, obs, exp);
        end
    endtask

    // One clock cycle on instance i: update the model, drive, clock, compare.
    task automatic step(input int i, input logic r, input logic c, input logic w,
                        input logic rd, input logic [7:0] d);
        int   sz;
        logic wa;
        logic ra;
        sz = msize[i];
        if (r) begin
            msize[i] = 0;
            movf[i]  = 1'b0;
            munf[i]  = 1'b0;
            mdout[i] = 8'h00;
        end else if (c) begin
            msize[i] = 0;
        end else begin
            wa = w && (sz < DEPTH_M[i]);
            ra = rd && (sz > 0);
            if (w && sz == DEPTH_M[i]) movf[i] = 1'b1;
            if (rd && sz == 0) munf[i] = 1'b1;
            if (ra) begin
                if (FWFT_M[i] == 0) mdout[i] = mdata[i][0];
                for (int k = 0; k < 15; k++) mdata[i][k] = mdata[i][k+1];
                msize[i] = msize[i] - 1;
            end
            if (wa) begin
                mdata[i][msize[i]] = d;
                msize[i] = msize[i] + 1;
            end
            if (FWFT_M[i] == 1 && (ra || wa) && msize[i] > 0) mdout[i] = mdata[i][0];
        end
        rst[i] = r; clr[i] = c; we[i] = w; re[i] = rd; din[i] = d;
        @(posedge clk);
        #1;
        rst[i] = 1'b0; clr[i] = 1'b0; we[i] = 1'b0; re[i] = 1'b0;
        $display("dut%0d rst=%0d clr=%0d we=%0d re=%0d din=%02h -> cnt=%0d dout=%02h e=%0d f=%0d ae=%0d af=%0d ov=%0d un=%0d",
                 i, r, c, w, rd, d, cnt[i], dout[i], empty[i], full[i], aempty[i], afull[i], ovf[i], unf[i]);
        chk("count",       i, 32'(cnt[i]),    32'(msize[i]));
        chk("empty",       i, 32'(empty[i]),  32'(msize[i] == 0));
        chk("full",        i, 32'(full[i]),   32'(msize[i] == DEPTH_M[i]));
        chk("almostfull",  i, 32'(afull[i]),  32'(msize[i] >= AF_M[i]));
        chk("almostempty", i, 32'(aempty[i]), 32'(msize[i] <= AE_M[i]));
        chk("overflow",    i, 32'(ovf[i]),    32'(movf[i]));
        chk("underflow",   i, 32'(unf[i]),    32'(munf[i]));
        chk("data",        i, 32'(dout[i]),   32'(mdout[i]));
    endtask

    task automatic random_steps(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            step(i, ($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 55),
                 8'($urandom));
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; clr[i] = 1'b0; we[i] = 1'b0; re[i] = 1'b0; din[i] = 8'h00;
            msize[i] = 0; movf[i] = 1'b0; munf[i] = 1'b0; mdout[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        // Depth 5, standard read: fill, overflow, drain, underflow.
        step(0, 1, 0, 0, 0, 8'h00);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 0, 8'(8'h11 + k));
        step(0, 0, 0, 1, 0, 8'h99);
        step(0, 0, 0, 1, 1, 8'h77);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 1, 1, 8'h42);
        step(0, 0, 0, 0, 1, 8'h00);
        random_steps(0, 250);

        // Depth 16: sustained read+write at count 3 across pointer wraps.
        step(1, 1, 0, 0, 0, 8'h00);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 1, 0, 8'(8'h30 + k));
        for (int k = 0; k < 40; k++) step(1, 0, 0, 1, 1, 8'($urandom));
        // Threshold walk: fill to 16 then drain to 0.
        for (int k = 0; k < 13; k++) step(1, 0, 0, 1, 0, 8'(8'h60 + k));
        for (int k = 0; k < 16; k++) step(1, 0, 0, 0, 1, 8'h00);
        // Underflow, clear at count 7, then reset.
        step(1, 0, 0, 0, 1, 8'h00);
        for (int k = 0; k < 7; k++) step(1, 0, 0, 1, 0, 8'(8'hC0 + k));
        step(1, 0, 1, 1, 1, 8'hEE);
        step(1, 0, 0, 0, 0, 8'h00);
        step(1, 1, 0, 0, 0, 8'h00);
        // Reset mid-burst together with write and read.
        for (int k = 0; k < 4; k++) step(1, 0, 0, 1, 0, 8'(8'hD0 + k));
        step(1, 0, 0, 1, 1, 8'hD4);
        step(1, 1, 0, 1, 1, 8'hDD);
        step(1, 0, 0, 0, 0, 8'h00);
        random_steps(1, 300);

        // FWFT: single write bypasses to Data_out, single read empties.
        step(2, 1, 0, 0, 0, 8'h00);
        step(2, 0, 0, 1, 0, 8'hA5);
        step(2, 0, 0, 0, 1, 8'h00);
        step(2, 0, 0, 1, 0, 8'h01);
        step(2, 0, 0, 1, 1, 8'h02);
        step(2, 0, 0, 1, 0, 8'h03);
        step(2, 0, 0, 0, 1, 8'h00);
        step(2, 0, 0, 0, 1, 8'h00);
        random_steps(2, 300);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
